sub_result_stage: RTL and testbench

Registered output stage directly downstream of the subtractor. It captures the subtractor's `SIZE+1`-bit result and overflow bit through a valid/ready handshake and holds them in a 2-entry skid FIFO. It derives zero, negative and overflow flags per entry and keeps a saturating count of overflow events. It decouples the combinational subtractor from the ALU result bus, so the downstream consumer can stall without losing operations.

---
 rtl/sub_result_if.sv | 26 ++
 rtl/sub_result_stage.sv | 129 ++++++++++++
 tb/tb_sub_result_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sub_result_if.sv
// Handshake bundle between the subtractor, the result stage and the result-bus consumer.
// The slave modport is the result stage itself; the master modport is the surrounding environment.
interface sub_result_if #(
  parameter int SIZE = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE:0]   in_result;
  logic            in_overflow;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_result;
  logic            out_zero;
  logic            out_negative;
  logic            out_overflow;

  modport slave (
    input  in_valid, in_result, in_overflow, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_negative, out_overflow
  );

  modport master (
    output in_valid, in_result, in_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_negative, out_overflow
  );
endinterface

// File: rtl/sub_result_stage.sv
// Registered 2-entry skid stage behind the subtractor with per-entry Z/N/V flags and a
// saturating overflow-event counter. Define SUB_STICKY_OVF_EN to add the ovf_sticky output.
module sub_result_stage #(
  parameter int SIZE      = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sub_result_if.slave          bus,
  input  logic                 clr_count,
`ifdef SUB_STICKY_OVF_EN
  output logic                 ovf_sticky,
`endif
  output logic [CNT_WIDTH-1:0] ovf_count
);

  typedef struct packed {
    logic [SIZE-1:0] result;
    logic            zero;
    logic            negative;
    logic            overflow;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  // Negative comes from the extra sign bit so it stays correct when the SIZE-bit view overflowed.
  function automatic entry_t make_entry(input logic [SIZE:0] res, input logic ovf);
    entry_t e;
    e.result   = res[SIZE-1:0];
    e.zero     = (res[SIZE-1:0] == '0);
    e.negative = res[SIZE];
    e.overflow = ovf;
    return e;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t state;
  entry_t head;
  entry_t tail;
  entry_t entry_in;
  logic   in_ready_r;
  logic   out_valid_r;
  logic   accept;
  logic   pop;
  logic   count_ovf;

  assign entry_in  = make_entry(bus.in_result, bus.in_overflow);
  assign accept    = bus.in_valid && in_ready_r;
  assign pop       = out_valid_r && bus.out_ready;
  assign count_ovf = accept && bus.in_overflow;

  // Occupancy FSM: head is always the entry on the output bus, tail is the skid slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      head        <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head        <= entry_in;
            state       <= ONE;
            out_valid_r <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            tail       <= entry_in;
            state      <= TWO;
            in_ready_r <= 1'b0;
          end else if (pop && !accept) begin
            state       <= EMPTY;
            out_valid_r <= 1'b0;
          end else if (accept && pop) begin
            head <= entry_in;
          end
        end
        TWO: begin
          if (pop) begin
            head       <= tail;
            state      <= ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // A counted accept on the clear edge restarts the count at 1 rather than losing the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (clr_count) begin
      ovf_count <= count_ovf ? CNT_WIDTH'(1) : '0;
    end else if (count_ovf) begin
      ovf_count <= sat_inc(ovf_count);
    end
  end

`ifdef SUB_STICKY_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (count_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (clr_count) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_result   = head.result;
  assign bus.out_zero     = head.zero;
  assign bus.out_negative = head.negative;
  assign bus.out_overflow = head.overflow;

endmodule

// File: tb/tb_sub_result_stage.sv
// Self-checking bench for sub_result_stage (SIZE=4, CNT_WIDTH=2) with a queue-based reference model.
module tb_sub_result_stage;
  localparam int SIZE = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_count;
  logic [CW-1:0] ovf_count;
`ifdef SUB_STICKY_OVF_EN
  logic          ovf_sticky;
`endif

  sub_result_if #(.SIZE(SIZE)) bus ();

  sub_result_stage #(.SIZE(SIZE), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr_count (clr_count),
`ifdef SUB_STICKY_OVF_EN
    .ovf_sticky(ovf_sticky),
`endif
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    bit neg;
    bit ovf;
  } mentry_t;

  mentry_t mq[$];
  int      mcnt;
  bit      msticky;
  int      checks = 0;
  int      errors = 0;

  typedef struct {
    logic [4:0] res;
    logic       ovf;
    logic [3:0] er;
    logic       ez;
    logic       en;
    logic       ev;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, tick, then compare DUT to model.
  task automatic cycle(input logic v, input logic [4:0] r, input logic o,
                       input logic rdy, input logic clr, input logic rs);
    bit      acc, pp;
    mentry_t e;
    bus.in_valid    = v;
    bus.in_result   = r;
    bus.in_overflow = o;
    bus.out_ready   = rdy;
    clr_count       = clr;
    rst             = rs;
    acc = v && !rs && (mq.size() < 2);
    pp  = !rs && (mq.size() > 0) && rdy;
    @(posedge clk);
    #1;
    if (rs) begin
      mq.delete();
      mcnt    = 0;
      msticky = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) begin
        e.res = int'(r) % 16;
        e.neg = (int'(r) >= 16);
        e.ovf = o;
        mq.push_back(e);
      end
      if (clr) mcnt = (acc && o) ? 1 : 0;
      else if (acc && o && mcnt < CMAX) mcnt = mcnt + 1;
      if (acc && o) msticky = 1;
      else if (clr) msticky = 0;
    end
    chk("out_valid", bus.out_valid, mq.size() > 0);
    chk("in_ready", bus.in_ready, mq.size() < 2);
    chk("ovf_count", ovf_count, mcnt);
    if (mq.size() > 0) begin
      chk("out_result", bus.out_result, mq[0].res);
      chk("out_zero", bus.out_zero, mq[0].res == 0);
      chk("out_negative", bus.out_negative, mq[0].neg);
      chk("out_overflow", bus.out_overflow, mq[0].ovf);
    end
`ifdef SUB_STICKY_OVF_EN
    chk("ovf_sticky", ovf_sticky, msticky);
`endif
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 5'h00, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0] = '{5'h02, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{5'h00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{5'h1F, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{5'h17, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1};

    mcnt = 0;
    msticky = 0;
    cycle(1'b1, 5'h17, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_flags", {bus.out_zero, bus.out_negative, bus.out_overflow}, 0);
    chk("rst_ovf_count", ovf_count, 0);

    // Back-to-back entries with the consumer always ready.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, tbl[i].res, tbl[i].ovf, 1'b1, 1'b0, 1'b0);
      chk("tbl_valid", bus.out_valid, 1);
      chk("tbl_result", bus.out_result, tbl[i].er);
      chk("tbl_zvn", {bus.out_zero, bus.out_negative, bus.out_overflow},
          {tbl[i].ez, tbl[i].en, tbl[i].ev});
    end
    chk("tbl_ovf_count", ovf_count, 1);
    idle(1'b1);
    chk("drain_valid", bus.out_valid, 0);

    // Stall: fill both slots, third entry waits, then drain in order.
    cycle(1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_ready1", bus.in_ready, 1);
    cycle(1'b1, 5'h09, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_ready2", bus.in_ready, 0);
    cycle(1'b1, 5'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_hold", bus.out_result, 4'h1);
    cycle(1'b1, 5'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_second", {bus.out_result, bus.out_negative, bus.out_overflow}, {4'h9, 1'b0, 1'b1});
    chk("stall_ready3", bus.in_ready, 1);
    cycle(1'b1, 5'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("stall_third", bus.out_result, 4'h3);
    idle(1'b1);
    chk("stall_empty", bus.out_valid, 0);

    // Saturation, then clear coinciding with a counted accept.
    cycle(1'b0, 5'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_zero", ovf_count, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 5'h10, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("sat_count", ovf_count, (i < 3) ? i + 1 : 3);
    end
    cycle(1'b1, 5'h10, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_with_ovf", ovf_count, 1);
    idle(1'b1);

    // Reset while full; post-reset entry emerges alone.
    cycle(1'b1, 5'h0A, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_before_rst", bus.in_ready, 0);
    cycle(1'b1, 5'h0C, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_ready", bus.in_ready, 1);
    chk("midrst_count", ovf_count, 0);
    cycle(1'b1, 5'h05, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_result", {bus.out_valid, bus.out_result}, {1'b1, 4'h5});
    idle(1'b1);
    chk("post_rst_alone", bus.out_valid, 0);

    // Sticky overflow: set by 5'h08/1 (N from bit SIZE stays 0), held, then cleared.
    cycle(1'b1, 5'h08, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("neg_uses_sign_bit", bus.out_negative, 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SUB_STICKY_OVF_EN
    chk("sticky_held", ovf_sticky, 1);
`endif
    cycle(1'b0, 5'h00, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef SUB_STICKY_OVF_EN
    chk("sticky_cleared", ovf_sticky, 0);
`endif

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
